// File: rtl/bids22_cmd_sequencer.sv
// bids22_cmd_sequencer: host command FIFO plus a dispatcher that keeps a single
// command outstanding on the bid-round controller at a time.
// Define BIDS22_SEQ_TIMEOUT_EN to add a WAIT-state timeout (TIMEOUT cycles).
module bids22_cmd_sequencer #(
    parameter int DATAWIDTH  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [3:0]                        cmd_op,
    input  logic [DATAWIDTH-1:0]              cmd_data,
    output logic [3:0]                        C_op,
    output logic [DATAWIDTH-1:0]              C_data,
    output logic                              C_start,
    input  logic                              ready,
    input  logic [2:0]                        err,
    output logic                              rsp_valid,
    output logic [3:0]                        rsp_op,
    output logic [2:0]                        rsp_err,
    output logic                              rsp_timeout,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH):0]       count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]           state;
    logic [DATAWIDTH+3:0] mem [FIFO_DEPTH];
    logic [DATAWIDTH+3:0] head;
    logic [AW-1:0]        wptr;
    logic [AW-1:0]        rptr;
    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 tmo;

    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    // Pop is the IDLE->ISSUE decision; the head is latched onto C_* on the same edge.
    assign pop       = (state == S_IDLE) && !empty && ready;
    assign head      = mem[rptr];
    assign C_start   = (state == S_ISSUE);
    assign rsp_valid = (state == S_RESP);
    assign busy      = !empty || (state != S_IDLE);

    // FIFO storage; contents need no reset since the pointers/count are flushed.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= {cmd_op, cmd_data};
    end

    // FIFO pointers and occupancy; push+pop together leaves count unchanged.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef BIDS22_SEQ_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [TW-1:0] tcnt;

    assign tmo = (tcnt == TW'(TIMEOUT));

    // WAIT cycle counter: zeroed during ISSUE so the first WAIT cycle reads 0.
    always_ff @(posedge clk) begin
        if (!reset_n)
            tcnt <= '0;
        else if (state == S_ISSUE)
            tcnt <= '0;
        else if (state == S_WAIT)
            tcnt <= tcnt + 1'b1;
    end
`else
    assign tmo = 1'b0;
`endif

    // Dispatcher: IDLE -> ISSUE (strobe) -> WAIT (for ready) -> RESP (pulse).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            C_op        <= '0;
            C_data      <= '0;
            rsp_op      <= '0;
            rsp_err     <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        C_op   <= head[DATAWIDTH+3:DATAWIDTH];
                        C_data <= head[DATAWIDTH-1:0];
                        rsp_op <= head[DATAWIDTH+3:DATAWIDTH];
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    // A real ready wins over a timeout landing in the same cycle.
                    if (ready) begin
                        rsp_err     <= err;
                        rsp_timeout <= 1'b0;
                        state       <= S_RESP;
                    end else if (tmo) begin
                        rsp_err     <= '0;
                        rsp_timeout <= 1'b1;
                        state       <= S_RESP;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bids22_cmd_sequencer.sv
// Directed bench for bids22_cmd_sequencer. Timeout scenarios run only when
// BIDS22_SEQ_TIMEOUT_EN is defined for both bench and design.
module tb_bids22_cmd_sequencer;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic [3:0]    C_op;
    logic [DW-1:0] C_data;
    logic          C_start;
    logic          ready;
    logic [2:0]    err;
    logic          rsp_valid;
    logic [3:0]    rsp_op;
    logic [2:0]    rsp_err;
    logic          rsp_timeout;
    logic          busy;
    logic [2:0]    count;

    bids22_cmd_sequencer #(.DATAWIDTH(DW), .FIFO_DEPTH(4), .TIMEOUT(10)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .C_op(C_op), .C_data(C_data),
        .C_start(C_start), .ready(ready), .err(err), .rsp_valid(rsp_valid),
        .rsp_op(rsp_op), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // issue / response log, filled at the falling edge
    int          iss_cyc[$];
    logic [3:0]  iss_op[$];
    logic [31:0] iss_dat[$];
    int          rsp_cyc[$];
    logic [3:0]  rsp_op_q[$];
    logic [2:0]  rsp_err_q[$];
    logic        rsp_to_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (C_start) begin
            iss_cyc.push_back(cyc); iss_op.push_back(C_op); iss_dat.push_back(C_data);
        end
        if (rsp_valid) begin
            rsp_cyc.push_back(cyc); rsp_op_q.push_back(rsp_op);
            rsp_err_q.push_back(rsp_err); rsp_to_q.push_back(rsp_timeout);
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        iss_cyc.delete(); iss_op.delete(); iss_dat.delete();
        rsp_cyc.delete(); rsp_op_q.delete(); rsp_err_q.delete(); rsp_to_q.delete();
    endtask

    // opcode table: UNLOCK, LOADX, LOADY, LOADZ, LOCK
    logic [3:0]  ops [5] = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd2};
    logic [31:0] dats[5] = '{32'hA5A5_0001, 32'h0000_0064, 32'h0000_00C8, 32'h0000_012C, 32'h5A5A_0002};

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; ready = 1'b0; err = '0;
        tick(); tick();
        // reset state
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_C_start", C_start, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_C_op", C_op, 0);
        check("rst_C_data", C_data, 0);
        reset_n = 1'b1;
        tick();

        // ---- single command, ready=1 ----
        clear_log();
        ready = 1'b1; cmd_valid = 1'b1; cmd_op = 4'd3; cmd_data = 32'h64;
        tick();                         // push edge t
        cmd_valid = 1'b0;
        check("t1_count", count, 1);
        check("t1_no_start_t1", C_start, 0);
        tick();                         // cycle t+2
        check("t1_start_t2", C_start, 1);
        check("t1_C_op", C_op, 3);
        check("t1_C_data", C_data, 32'h64);
        tick();                         // WAIT
        check("t1_start_once", C_start, 0);
        check("t1_no_rsp_wait", rsp_valid, 0);
        tick();                         // RESP
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_op", rsp_op, 3);
        check("t1_rsp_err", rsp_err, 0);
        check("t1_rsp_to", rsp_timeout, 0);
        tick();
        check("t1_rsp_pulse", rsp_valid, 0);
        check("t1_idle_busy", busy, 0);

        // ---- 5 pushes with ready=0, then drain with BADKEY on UNLOCK ----
        ready = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_op = ops[i]; cmd_data = dats[i];
            tick();
        end
        check("t2_full_ready", cmd_ready, 0);
        check("t2_full_count", count, 4);
        cmd_op = ops[4]; cmd_data = dats[4];
        tick(); tick();
        check("t2_held_count", count, 4);
        check("t2_held_start", C_start, 0);
        clear_log();
        ready = 1'b1; err = 3'd1;
        tick();                          // pop edge
        check("t2_ready_back", cmd_ready, 1);
        tick();                          // 5th pushed
        cmd_valid = 1'b0;
        check("t2_count_refill", count, 4);
        tick();                          // RESP of UNLOCK; err already sampled
        err = 3'd0;
        repeat (25) tick();
        check("t2_n_issue", iss_cyc.size(), 5);
        check("t2_n_rsp", rsp_cyc.size(), 5);
        if (iss_cyc.size() == 5 && rsp_cyc.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("t2_op%0d", i), iss_op[i], ops[i]);
                check($sformatf("t2_dat%0d", i), iss_dat[i], dats[i]);
                check($sformatf("t2_rsp_op%0d", i), rsp_op_q[i], ops[i]);
                check($sformatf("t2_rsp_err%0d", i), rsp_err_q[i], (i == 0) ? 3'd1 : 3'd0);
                check($sformatf("t2_rsp_lat%0d", i), rsp_cyc[i] - iss_cyc[i], 2);
                if (i > 0) check($sformatf("t2_space%0d", i), iss_cyc[i] - iss_cyc[i-1], 4);
            end
        end
        check("t2_drained", count, 0);
        check("t2_busy", busy, 0);

        // ---- simultaneous push and pop at count=2 ----
        ready = 1'b0; cmd_valid = 1'b1;
        cmd_op = 4'd6; cmd_data = 32'h11; tick();
        cmd_op = 4'd7; cmd_data = 32'h22; tick();
        check("t6_count2", count, 2);
        clear_log();
        cmd_op = 4'd8; cmd_data = 32'h33; ready = 1'b1;
        tick();                          // push + pop edge
        cmd_valid = 1'b0;
        check("t6_count_same", count, 2);
        check("t6_start", C_start, 1);
        repeat (15) tick();
        check("t6_n_issue", iss_cyc.size(), 3);
        if (iss_cyc.size() == 3) begin
            check("t6_op0", iss_op[0], 6);
            check("t6_op1", iss_op[1], 7);
            check("t6_op2", iss_op[2], 8);
            check("t6_dat2", iss_dat[2], 32'h33);
        end

`ifdef BIDS22_SEQ_TIMEOUT_EN
        // ---- timeout: ready stuck low ----
        clear_log();
        ready = 1'b1; err = 3'd3; cmd_valid = 1'b1; cmd_op = 4'd4; cmd_data = 32'h44;
        tick(); cmd_valid = 1'b0;
        tick();                          // ISSUE cycle
        ready = 1'b0;
        repeat (20) tick();
        check("to_n_rsp", rsp_cyc.size(), 1);
        if (rsp_cyc.size() == 1 && iss_cyc.size() == 1) begin
            check("to_lat", rsp_cyc[0] - iss_cyc[0], 12);
            check("to_flag", rsp_to_q[0], 1);
            check("to_err", rsp_err_q[0], 0);
        end
        // ---- ready rises in the expiry cycle ----
        clear_log();
        ready = 1'b1; err = 3'd2; cmd_valid = 1'b1; cmd_op = 4'd5; cmd_data = 32'h55;
        tick(); cmd_valid = 1'b0;
        tick();                          // ISSUE cycle k
        ready = 1'b0;
        repeat (11) tick();              // cycle k+11: counter at TIMEOUT
        ready = 1'b1;
        tick();
        ready = 1'b0;
        repeat (5) tick();
        check("tr_n_rsp", rsp_cyc.size(), 1);
        if (rsp_cyc.size() == 1 && iss_cyc.size() == 1) begin
            check("tr_lat", rsp_cyc[0] - iss_cyc[0], 12);
            check("tr_flag", rsp_to_q[0], 0);
            check("tr_err", rsp_err_q[0], 2);
        end
        err = 3'd0;
`endif

        // ---- reset during WAIT with 2 queued ----
        ready = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_op = ops[i]; cmd_data = dats[i]; tick();
        end
        cmd_valid = 1'b0;
        ready = 1'b1; tick();            // pop -> ISSUE
        ready = 1'b0; tick();            // WAIT
        check("t5_pre_count", count, 2);
        clear_log();
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        check("t5_count", count, 0);
        check("t5_busy", busy, 0);
        check("t5_rsp_valid", rsp_valid, 0);
        check("t5_C_op", C_op, 0);
        ready = 1'b1;
        repeat (8) tick();
        check("t5_no_issue", iss_cyc.size(), 0);
        check("t5_no_rsp", rsp_cyc.size(), 0);
        check("t5_busy_after", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
